// File: rtl/formula_nest_pipe.sv
// Nested integer square-root pipeline: res = isqrt(x[N-1] + isqrt(... + isqrt(x[0]))).
// Define FORMULA_NEST_PIPE_SAT_EN to saturate overflowing inner sums instead of wrapping.

// Digit-by-digit 32-bit isqrt. The 16 iterations are spread over N_PIPE_STAGES
// registers (1..16); the last iteration always ends in a register.
module formula_nest_isqrt #(
  parameter int N_PIPE_STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] in_data,
  output logic        out_vld,
  output logic [15:0] out_data,
  output logic        active
);
  logic [17:0] rem_s  [16];
  logic [15:0] root_s [17];
  logic [31:0] x_s    [16];
  logic [16:0] vld_s;

  assign rem_s[0]  = '0;
  assign root_s[0] = '0;
  assign x_s[0]    = in_data;
  assign vld_s[0]  = in_vld;

  for (genvar j = 0; j < 16; j++) begin : g_it
    localparam bit BRK = (((j + 1) * N_PIPE_STAGES) / 16) != ((j * N_PIPE_STAGES) / 16);
    logic [19:0] rem_sh;
    logic [19:0] trial;
    logic        ge;
    logic [15:0] root_n;

    assign rem_sh = {rem_s[j], x_s[j][31:30]};
    assign trial  = {2'b00, root_s[j], 2'b01};
    assign ge     = (rem_sh >= trial);
    assign root_n = {root_s[j][14:0], ge};

    if (j == 15) begin : g_last
      logic        vld_q;
      logic [15:0] root_q;
      // final iteration register: only the root leaves the core
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_s[j];
      end
      always_ff @(posedge clk) begin
        if (vld_s[j]) root_q <= root_n;
      end
      assign vld_s[16]  = vld_q;
      assign root_s[16] = root_q;
    end else begin : g_mid
      logic [17:0] diff;
      logic [17:0] rem_n;
      logic [31:0] x_n;

      assign diff  = rem_sh[17:0] - trial[17:0];
      assign rem_n = ge ? diff : rem_sh[17:0];
      assign x_n   = {x_s[j][29:0], 2'b00};

      if (BRK) begin : g_reg
        logic        vld_q;
        logic [15:0] root_q;
        logic [17:0] rem_q;
        logic [31:0] x_q;
        // intermediate iteration register
        always_ff @(posedge clk or posedge rst) begin
          if (rst) vld_q <= 1'b0;
          else     vld_q <= vld_s[j];
        end
        always_ff @(posedge clk) begin
          if (vld_s[j]) begin
            root_q <= root_n;
            rem_q  <= rem_n;
            x_q    <= x_n;
          end
        end
        assign vld_s[j+1]  = vld_q;
        assign root_s[j+1] = root_q;
        assign rem_s[j+1]  = rem_q;
        assign x_s[j+1]    = x_q;
      end else begin : g_wire
        assign vld_s[j+1]  = vld_s[j];
        assign root_s[j+1] = root_n;
        assign rem_s[j+1]  = rem_n;
        assign x_s[j+1]    = x_n;
      end
    end
  end

  assign out_vld  = vld_s[16];
  assign out_data = root_s[16];
  assign active   = |vld_s[15:0];
endmodule

module formula_nest_pipe #(
  parameter int N_LEVELS     = 3,
  parameter int ISQRT_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arg_vld,
  input  logic [32*N_LEVELS-1:0] x,
  output logic                  res_vld,
  output logic [15:0]           res,
  output logic                  res_ovf,
  output logic                  busy
);
  localparam logic [N_LEVELS-1:0] INNER_MASK = {N_LEVELS{1'b1}} >> 1;

  logic [31:0]         iso_in [N_LEVELS];
  logic [15:0]         y      [N_LEVELS];
  logic [N_LEVELS-1:0] iso_in_vld;
  logic [N_LEVELS-1:0] y_vld;
  logic [N_LEVELS-1:0] iso_act;
  logic [N_LEVELS-1:0] dl_act;
  logic [N_LEVELS-1:0] flag_out;
  logic [N_LEVELS-1:0] flag_vld;
  logic                busy_q;

`ifdef FORMULA_NEST_PIPE_SAT_EN
  function automatic logic [31:0] sat_arg(input logic [32:0] s);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
`endif

  for (genvar k = 0; k < N_LEVELS; k++) begin : g_lvl
    formula_nest_isqrt #(.N_PIPE_STAGES(ISQRT_STAGES)) u_isqrt (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (iso_in_vld[k]),
      .in_data  (iso_in[k]),
      .out_vld  (y_vld[k]),
      .out_data (y[k]),
      .active   (iso_act[k])
    );

    if (k == 0) begin : g_root
      assign iso_in[k]     = x[31:0];
      assign iso_in_vld[k] = arg_vld;
      assign dl_act[k]     = 1'b0;
      assign flag_out[k]   = 1'b0;
      assign flag_vld[k]   = 1'b1;
    end else begin : g_nest
      localparam int D = k * (ISQRT_STAGES + 1) - 1;
      logic [D-1:0]            xd_vld_p;
      logic [31:0]             xd_p [D];
      logic [32:0]             sum;
      logic                    en;
      logic                    add_vld_p1;
      logic [31:0]             add_data_p1;
      logic                    add_ovf_p1;
      logic [ISQRT_STAGES-1:0] fl_vld_p;
      logic                    fl_p [ISQRT_STAGES];

      assign sum = {1'b0, xd_p[D-1]} + {17'b0, y[k-1]};
      assign en  = y_vld[k-1] & flag_vld[k-1] & xd_vld_p[D-1];

      // operand delay line, adder stage and sticky-flag line share one valid scheme
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          xd_vld_p   <= '0;
          add_vld_p1 <= 1'b0;
          fl_vld_p   <= '0;
        end else begin
          xd_vld_p    <= xd_vld_p << 1;
          xd_vld_p[0] <= arg_vld;
          add_vld_p1  <= en;
          fl_vld_p    <= fl_vld_p << 1;
          fl_vld_p[0] <= add_vld_p1;
        end
      end

      always_ff @(posedge clk) begin
        if (arg_vld) xd_p[0] <= x[k*32 +: 32];
        for (int i = 1; i < D; i++) begin
          if (xd_vld_p[i-1]) xd_p[i] <= xd_p[i-1];
        end
        if (en) begin
`ifdef FORMULA_NEST_PIPE_SAT_EN
          add_data_p1 <= sat_arg(sum);
`else
          add_data_p1 <= sum[31:0];
`endif
          add_ovf_p1  <= sum[32] | flag_out[k-1];
        end
        if (add_vld_p1) fl_p[0] <= add_ovf_p1;
        for (int i = 1; i < ISQRT_STAGES; i++) begin
          if (fl_vld_p[i-1]) fl_p[i] <= fl_p[i-1];
        end
      end

      assign iso_in[k]     = add_data_p1;
      assign iso_in_vld[k] = add_vld_p1;
      assign dl_act[k]     = |xd_vld_p;
      assign flag_out[k]   = fl_p[ISQRT_STAGES-1];
      assign flag_vld[k]   = fl_vld_p[ISQRT_STAGES-1];
    end
  end

  // busy register: the presented result itself does not count as in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= arg_vld | (|iso_act) | (|dl_act) | (|(y_vld & INNER_MASK));
  end

  assign res_vld = y_vld[N_LEVELS-1];
  assign res     = y[N_LEVELS-1];
  assign res_ovf = flag_out[N_LEVELS-1] & flag_vld[N_LEVELS-1] & y_vld[N_LEVELS-1];
  assign busy    = busy_q;
endmodule

// File: tb/tb_formula_nest_pipe.sv
// Directed and model-checked bench for formula_nest_pipe at N_LEVELS = 1, 3 and 5.
module tb_formula_nest_pipe;
  localparam int L1 = 4;
  localparam int L3 = 14;
  localparam int L5 = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         v1, v3, v5;
  logic [31:0]  x1;
  logic [95:0]  x3;
  logic [159:0] x5;
  logic         rv1, rv3, rv5, ov1, ov3, ov5, b1, b3, b5;
  logic [15:0]  r1, r3, r5;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  formula_nest_pipe #(.N_LEVELS(3), .ISQRT_STAGES(4)) u3 (
    .clk(clk), .rst(rst), .arg_vld(v3), .x(x3),
    .res_vld(rv3), .res(r3), .res_ovf(ov3), .busy(b3));
  formula_nest_pipe #(.N_LEVELS(1), .ISQRT_STAGES(4)) u1 (
    .clk(clk), .rst(rst), .arg_vld(v1), .x(x1),
    .res_vld(rv1), .res(r1), .res_ovf(ov1), .busy(b1));
  formula_nest_pipe #(.N_LEVELS(5), .ISQRT_STAGES(4)) u5 (
    .clk(clk), .rst(rst), .arg_vld(v5), .x(x5),
    .res_vld(rv5), .res(r5), .res_ovf(ov5), .busy(b5));

  function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
    longint lo = 0;
    longint hi = 65535;
    longint mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return 16'(lo);
  endfunction

  // returns {ovf, res}
  function automatic logic [16:0] ref_nest(input logic [255:0] xs, input int n);
    logic [15:0] yy;
    logic        ovf;
    logic [32:0] s;
    ovf = 1'b0;
    yy  = ref_isqrt(xs[31:0]);
    for (int k = 1; k < n; k++) begin
      s = {1'b0, xs[k*32 +: 32]} + {17'b0, yy};
      if (s[32]) ovf = 1'b1;
`ifdef FORMULA_NEST_PIPE_SAT_EN
      yy = ref_isqrt(s[32] ? 32'hFFFF_FFFF : s[31:0]);
`else
      yy = ref_isqrt(s[31:0]);
`endif
    end
    return {ovf, yy};
  endfunction

  task automatic drive(input int dut, input logic v, input logic [255:0] xv);
    case (dut)
      1:       begin v1 = v; x1 = xv[31:0];  end
      5:       begin v5 = v; x5 = xv[159:0]; end
      default: begin v3 = v; x3 = xv[95:0];  end
    endcase
  endtask

  task automatic read(input int dut, output logic rv, output logic ov,
                      output logic bz, output logic [15:0] r);
    case (dut)
      1:       begin rv = rv1; ov = ov1; bz = b1; r = r1; end
      5:       begin rv = rv5; ov = ov5; bz = b5; r = r5; end
      default: begin rv = rv3; ov = ov3; bz = b3; r = r3; end
    endcase
  endtask

  // one isolated beat: checks latency, value, flag and busy window
  task automatic beat(input string name, input int dut, input logic [255:0] xv,
                      input logic [15:0] er, input logic eo);
    int lat;
    logic rv, ov, bz;
    logic [15:0] r;
    lat = (dut == 1) ? L1 : (dut == 5) ? L5 : L3;
    @(posedge clk); #1;
    drive(dut, 1'b1, xv);
    for (int it = 1; it <= lat + 1; it++) begin
      @(posedge clk); #1;
      if (it == 1) drive(dut, 1'b0, xv);
      read(dut, rv, ov, bz, r);
      n_tests++;
      if (rv !== (it == lat)) begin
        n_fail++;
        $display("FAIL %s res_vld cycle %0d: got %b want %b", name, it, rv, (it == lat));
      end
      n_tests++;
      if (bz !== (it <= lat)) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, it, bz, (it <= lat));
      end
      n_tests++;
      if (it == lat) begin
        if (r !== er || ov !== eo) begin
          n_fail++;
          $display("FAIL %s result: got res=%0d ovf=%b want res=%0d ovf=%b", name, r, ov, er, eo);
        end
      end else if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL %s res_ovf outside res_vld cycle %0d: got %b want 0", name, it, ov);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1 = 1'b0; v3 = 1'b0; v5 = 1'b0;
    x1 = '0; x3 = '0; x5 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({rv1, rv3, rv5, ov1, ov3, ov5, b1, b3, b5} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want 000000000",
               {rv1, rv3, rv5, ov1, ov3, ov5, b1, b3, b5});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [255:0] xv;
    xv = '0; xv[95:0] = {32'd9, 32'd12, 32'd16};
    beat("one_beat", 3, xv, 16'd3, 1'b0);
    xv = '0; xv[95:0] = {32'd2, 32'd1, 32'd15};
    beat("small_mix", 3, xv, 16'd2, 1'b0);
    xv = '0; xv[95:0] = {32'd1, 32'd0, 32'hFFFF_FFFF};
    beat("max_inner", 3, xv, 16'd16, 1'b0);
    xv = '0;
    beat("all_zero", 3, xv, 16'd0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [255:0] xv;
    xv = '0; xv[95:0] = {32'd0, 32'hFFFF_FFFF, 32'd4};
`ifdef FORMULA_NEST_PIPE_SAT_EN
    beat("ovf_sat", 3, xv, 16'd255, 1'b1);
`else
    beat("ovf_wrap", 3, xv, 16'd1, 1'b1);
`endif
  endtask

  // streaming on the 3-level block: output pattern must be the input pattern shifted by L3
  task automatic run_stream(input string name, input int nb, input int bubble_pct);
    logic        dv [300];
    logic [95:0] dx [300];
    logic [16:0] e;
    logic        ev;
    int          j;
    for (int i = 0; i < nb; i++) begin
      dv[i] = ($urandom_range(99) >= bubble_pct);
      if ($urandom_range(1) == 0) dx[i] = {$urandom, $urandom, $urandom};
      else dx[i] = {32'($urandom_range(70000)), 32'($urandom_range(70000)),
                    32'($urandom_range(70000))};
    end
    for (int it = 0; it < nb + L3 + 2; it++) begin
      @(posedge clk); #1;
      j  = it - L3;
      ev = (j >= 0 && j < nb) ? dv[j] : 1'b0;
      n_tests++;
      if (rv3 !== ev) begin
        n_fail++;
        $display("FAIL %s res_vld cycle %0d: got %b want %b", name, it, rv3, ev);
      end else if (ev) begin
        e = ref_nest({160'b0, dx[j]}, 3);
        n_tests++;
        if ({ov3, r3} !== e) begin
          n_fail++;
          $display("FAIL %s beat %0d: got res=%0d ovf=%b want res=%0d ovf=%b",
                   name, j, r3, ov3, e[15:0], e[16]);
        end
      end
      if (it < nb) begin v3 = dv[it]; x3 = dx[it]; end
      else begin v3 = 1'b0; x3 = '0; end
    end
    n_tests++;
    if (b3 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after drain: got %b want 0", name, b3);
    end
  endtask

  task automatic test_back_to_back();
    run_stream("back_to_back", 200, 0);
  endtask

  task automatic test_bubbles();
    run_stream("bubbles", 120, 40);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (rv3 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset early res_vld %0d: got %b want 0", i, rv3);
      end
      v3 = 1'b1;
      x3 = {32'(i), 32'(i * 7), 32'(i * 100)};
    end
    @(posedge clk); #1;
    v3  = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (b3 !== 1'b0 || rv3 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset immediate: got busy=%b res_vld=%b want 0 0", b3, rv3);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    v3  = 1'b1;
    x3  = {32'd21, 32'd6, 32'd100};
    for (int it = 1; it <= L3 + 2; it++) begin
      @(posedge clk); #1;
      v3 = 1'b0;
      n_tests++;
      if (rv3 !== (it == L3)) begin
        n_fail++;
        $display("FAIL mid_reset res_vld cycle %0d: got %b want %b", it, rv3, (it == L3));
      end
      if (it == L3) begin
        n_tests++;
        if (r3 !== 16'd5 || ov3 !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_reset result: got res=%0d ovf=%b want res=5 ovf=0", r3, ov3);
        end
      end
    end
  endtask

  task automatic test_n1();
    logic [255:0] xv;
    xv = '0; xv[31:0] = 32'd1000;
    beat("n1_1000", 1, xv, 16'd31, 1'b0);
    xv = '0; xv[31:0] = 32'hFFFF_FFFF;
    beat("n1_max", 1, xv, 16'd65535, 1'b0);
  endtask

  task automatic test_n5();
    logic [255:0] xv;
    logic [16:0]  e;
    xv = '0; xv[159:0] = {32'd93, 32'd45, 32'd12, 32'd7, 32'd81};
    beat("n5_directed", 5, xv, 16'd10, 1'b0);
    for (int b = 0; b < 3; b++) begin
      xv = '0;
      for (int k = 0; k < 5; k++) begin
        xv[k*32 +: 32] = (b == 1) ? 32'($urandom_range(5000)) : $urandom;
      end
      e = ref_nest(xv, 5);
      beat("n5_model", 5, xv, e[15:0], e[16]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_back_to_back();
    test_bubbles();
    test_mid_reset();
    test_n1();
    test_n5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
